// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a time,
// and presents {pc, instr} to decode through an output register backed by a one-entry hold buffer.
module fetch #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_exec_stall,
    input  logic        i_mem_stall,
    input  logic        i_jump_valid,
    input  logic [31:0] i_jump_addr,
    input  logic        i_drop,
    output logic [31:0] o_ibus_addr,
    output logic        o_ibus_rd,
    input  logic [31:0] i_ibus_data,
    input  logic        i_ibus_rdy,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_fetch_stall
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_addr;
    logic        r_out_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_hold_data;
    logic [31:0] r_hold_pc;

    state_t      w_state_nxt;
    logic [31:0] w_fetch_pc_nxt;
    logic        w_out_valid_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_hold_data_nxt;
    logic [31:0] w_hold_pc_nxt;
    logic        w_consume;
    logic        w_out_free;
    logic [31:0] w_ibus_addr;
    logic [31:0] w_jump_pc;

    assign w_consume  = r_out_valid & ~i_exec_stall & ~i_mem_stall;
    assign w_out_free = ~r_out_valid | w_consume | i_drop;
    assign w_jump_pc  = i_jump_addr & ~32'h0000_0003;

    // In DISCARD the bus must keep seeing the stale address even though the PC has moved on.
    assign w_ibus_addr   = (r_state == S_DISCARD) ? r_req_addr : r_fetch_pc;
    assign o_ibus_addr   = w_ibus_addr;
    assign o_ibus_rd     = ~rst & (r_state != S_HOLD);
    assign o_pc          = r_pc;
    assign o_instr       = r_instr;
    assign o_fetch_stall = ~r_out_valid;

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_out_valid_nxt = r_out_valid;
        w_instr_nxt     = r_instr;
        w_pc_nxt        = r_pc;
        w_hold_data_nxt = r_hold_data;
        w_hold_pc_nxt   = r_hold_pc;

        if (w_consume || i_drop) begin
            w_out_valid_nxt = 1'b0;
            w_instr_nxt     = NOP_INSTR;
        end

        unique case (r_state)
            S_FETCH: begin
                if (i_ibus_rdy) begin
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    if (w_out_free) begin
                        w_out_valid_nxt = 1'b1;
                        w_instr_nxt     = i_ibus_data;
                        w_pc_nxt        = r_fetch_pc;
                    end else begin
                        w_hold_data_nxt = i_ibus_data;
                        w_hold_pc_nxt   = r_fetch_pc;
                        w_state_nxt     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (i_drop) begin
                    w_state_nxt = S_FETCH;
                end else if (w_consume) begin
                    w_out_valid_nxt = 1'b1;
                    w_instr_nxt     = r_hold_data;
                    w_pc_nxt        = r_hold_pc;
                    w_state_nxt     = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (i_ibus_rdy) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase

        // A redirect overrides any load, consume or drop decided above.
        if (i_jump_valid) begin
            w_fetch_pc_nxt  = w_jump_pc;
            w_out_valid_nxt = 1'b0;
            w_instr_nxt     = NOP_INSTR;
            w_pc_nxt        = r_pc;
            if ((r_state != S_HOLD) && !i_ibus_rdy) begin
                w_state_nxt = S_DISCARD;
            end else begin
                w_state_nxt = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state     <= S_FETCH;
            r_fetch_pc  <= RESET_PC;
            r_out_valid <= 1'b0;
            r_instr     <= NOP_INSTR;
            r_pc        <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_instr     <= w_instr_nxt;
            r_pc        <= w_pc_nxt;
        end
    end

    // NOTE: hold buffer and request-address copy are data-only, qualified by r_state, so they skip reset.
    always_ff @(posedge clk) begin
        r_hold_data <= w_hold_data_nxt;
        r_hold_pc   <= w_hold_pc_nxt;
        r_req_addr  <= w_ibus_addr;
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus a randomized run checked against
// a program-order PC model on the decode side.
module tb_fetch;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        exec_stall, mem_stall, jump_valid, drop, ibus_rdy;
    logic [31:0] jump_addr, ibus_data;
    logic [31:0] o_ibus_addr, o_pc, o_instr;
    logic        o_ibus_rd, o_fetch_stall;
    logic [31:0] w_ibus_addr, w_pc, w_instr;
    logic        w_ibus_rd, w_fetch_stall;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          auto_rdy = 1'b0;
    logic [31:0] tb_pc;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) u_dut (
        .clk(clk), .rst(rst), .i_exec_stall(exec_stall), .i_mem_stall(mem_stall),
        .i_jump_valid(jump_valid), .i_jump_addr(jump_addr), .i_drop(drop),
        .o_ibus_addr(o_ibus_addr), .o_ibus_rd(o_ibus_rd), .i_ibus_data(ibus_data),
        .i_ibus_rdy(ibus_rdy), .o_pc(o_pc), .o_instr(o_instr), .o_fetch_stall(o_fetch_stall)
    );

    fetch #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) u_wrap (
        .clk(clk), .rst(rst), .i_exec_stall(exec_stall), .i_mem_stall(mem_stall),
        .i_jump_valid(jump_valid), .i_jump_addr(jump_addr), .i_drop(drop),
        .o_ibus_addr(w_ibus_addr), .o_ibus_rd(w_ibus_rd), .i_ibus_data(ibus_data),
        .i_ibus_rdy(ibus_rdy), .o_pc(w_pc), .o_instr(w_instr), .o_fetch_stall(w_fetch_stall)
    );

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic bus_update();
        ibus_data = data_of(o_ibus_addr);
        if (auto_rdy) ibus_rdy = o_ibus_rd;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        bus_update();
    endtask

    task automatic do_reset();
        rst = 1'b1; exec_stall = 1'b0; mem_stall = 1'b0; jump_valid = 1'b0;
        jump_addr = '0; drop = 1'b0; ibus_rdy = 1'b0; auto_rdy = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        auto_rdy = 1'b1;
        bus_update();
    endtask

    task automatic test_reset();
        rst = 1'b1; exec_stall = 1'b0; mem_stall = 1'b0; jump_valid = 1'b0;
        jump_addr = '0; drop = 1'b0; ibus_rdy = 1'b0; ibus_data = '0; auto_rdy = 1'b0;
        cyc(); cyc();
        n_checks++; if (o_ibus_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", o_ibus_rd); end
        n_checks++; if (o_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", o_fetch_stall); end
        n_checks++; if (o_instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", o_instr, NOP); end
        n_checks++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", o_pc); end
        rst = 1'b0;
        #1;
        auto_rdy = 1'b1;
        bus_update();
        n_checks++; if (o_ibus_rd !== 1'b1) begin n_fail++; $display("FAIL release_rd: got %b want 1", o_ibus_rd); end
        n_checks++; if (o_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL release_stall: got %b want 1", o_fetch_stall); end
    endtask

    // Rdy every cycle, no stalls: one instruction per cycle, also exercising PC wrap on u_wrap.
    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ea, wa;
            ea = RESET_PC + 32'(4 * i);
            wa = WRAP_PC + 32'(4 * i);
            n_checks++; if (o_ibus_addr !== ea) begin n_fail++; $display("FAIL stream_addr%0d: got %h want %h", i, o_ibus_addr, ea); end
            n_checks++; if (w_ibus_addr !== wa) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, w_ibus_addr, wa); end
            cyc();
            n_checks++; if (o_pc !== ea) begin n_fail++; $display("FAIL stream_pc%0d: got %h want %h", i, o_pc, ea); end
            n_checks++; if (o_instr !== data_of(ea)) begin n_fail++; $display("FAIL stream_instr%0d: got %h want %h", i, o_instr, data_of(ea)); end
            n_checks++; if (o_fetch_stall !== 1'b0) begin n_fail++; $display("FAIL stream_stall%0d: got %b want 0", i, o_fetch_stall); end
            n_checks++; if (w_pc !== wa) begin n_fail++; $display("FAIL wrap_pc%0d: got %h want %h", i, w_pc, wa); end
        end
        tb_pc = RESET_PC + 32'd12;
    endtask

    task automatic test_exec_stall();
        exec_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++; if (o_ibus_rd !== 1'b0) begin n_fail++; $display("FAIL hold_rd%0d: got %b want 0", k, o_ibus_rd); end
            n_checks++; if (o_pc !== tb_pc) begin n_fail++; $display("FAIL hold_pc%0d: got %h want %h", k, o_pc, tb_pc); end
            n_checks++; if (o_instr !== data_of(tb_pc)) begin n_fail++; $display("FAIL hold_instr%0d: got %h want %h", k, o_instr, data_of(tb_pc)); end
        end
        exec_stall = 1'b0;
        cyc();
        n_checks++; if (o_pc !== tb_pc + 32'd4) begin n_fail++; $display("FAIL unhold_pc: got %h want %h", o_pc, tb_pc + 32'd4); end
        n_checks++; if (o_instr !== data_of(tb_pc + 32'd4)) begin n_fail++; $display("FAIL unhold_instr: got %h want %h", o_instr, data_of(tb_pc + 32'd4)); end
        n_checks++; if (o_ibus_addr !== tb_pc + 32'd8) begin n_fail++; $display("FAIL unhold_addr: got %h want %h", o_ibus_addr, tb_pc + 32'd8); end
        cyc();
        n_checks++; if (o_pc !== tb_pc + 32'd8) begin n_fail++; $display("FAIL unhold_next_pc: got %h want %h", o_pc, tb_pc + 32'd8); end
        tb_pc = tb_pc + 32'd8;
    endtask

    task automatic test_redirect_discard();
        do_reset();
        cyc(); cyc(); cyc(); cyc();
        n_checks++; if (o_ibus_addr !== RESET_PC + 32'h10) begin n_fail++; $display("FAIL disc_setup_addr: got %h want %h", o_ibus_addr, RESET_PC + 32'h10); end
        auto_rdy = 1'b0; ibus_rdy = 1'b0;
        jump_valid = 1'b1; jump_addr = 32'h0000_0103;
        cyc();
        jump_valid = 1'b0;
        n_checks++; if (o_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL disc_stall: got %b want 1", o_fetch_stall); end
        n_checks++; if (o_instr !== NOP) begin n_fail++; $display("FAIL disc_instr: got %h want %h", o_instr, NOP); end
        n_checks++; if (o_ibus_rd !== 1'b1 || o_ibus_addr !== RESET_PC + 32'h10) begin n_fail++; $display("FAIL disc_stale_addr: got rd=%b %h want rd=1 %h", o_ibus_rd, o_ibus_addr, RESET_PC + 32'h10); end
        cyc();
        n_checks++; if (o_ibus_addr !== RESET_PC + 32'h10) begin n_fail++; $display("FAIL disc_addr_stable: got %h want %h", o_ibus_addr, RESET_PC + 32'h10); end
        ibus_rdy = 1'b1;
        cyc();
        n_checks++; if (o_ibus_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL disc_target_addr: got %h want 00000100", o_ibus_addr); end
        n_checks++; if (o_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL disc_dropped: got stall=%b want 1", o_fetch_stall); end
        auto_rdy = 1'b1;
        bus_update();
        cyc();
        n_checks++; if (o_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL disc_target_pc: got %h want 00000100", o_pc); end
        n_checks++; if (o_instr !== data_of(32'h100)) begin n_fail++; $display("FAIL disc_target_instr: got %h want %h", o_instr, data_of(32'h100)); end
        tb_pc = 32'h0000_0100;
    endtask

    task automatic test_jump_with_rdy();
        jump_valid = 1'b1; jump_addr = 32'h0000_2002;
        cyc();
        jump_valid = 1'b0;
        n_checks++; if (o_ibus_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL jrdy_addr: got %h want 00002000", o_ibus_addr); end
        n_checks++; if (o_fetch_stall !== 1'b1 || o_instr !== NOP) begin n_fail++; $display("FAIL jrdy_nop: got stall=%b instr=%h want 1 %h", o_fetch_stall, o_instr, NOP); end
        cyc();
        n_checks++; if (o_pc !== 32'h0000_2000) begin n_fail++; $display("FAIL jrdy_pc: got %h want 00002000", o_pc); end
        n_checks++; if (o_instr !== data_of(32'h2000)) begin n_fail++; $display("FAIL jrdy_instr: got %h want %h", o_instr, data_of(32'h2000)); end
        tb_pc = 32'h0000_2000;
    endtask

    task automatic test_drop();
        exec_stall = 1'b1;
        cyc();
        n_checks++; if (o_pc !== tb_pc || o_fetch_stall !== 1'b0) begin n_fail++; $display("FAIL drop_setup: got pc=%h stall=%b want %h 0", o_pc, o_fetch_stall, tb_pc); end
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        n_checks++; if (o_instr !== NOP) begin n_fail++; $display("FAIL drop_instr: got %h want %h", o_instr, NOP); end
        n_checks++; if (o_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL drop_stall: got %b want 1", o_fetch_stall); end
        n_checks++; if (o_ibus_rd !== 1'b1 || o_ibus_addr !== tb_pc + 32'd8) begin n_fail++; $display("FAIL drop_addr: got rd=%b %h want rd=1 %h", o_ibus_rd, o_ibus_addr, tb_pc + 32'd8); end
        exec_stall = 1'b0;
        cyc();
        n_checks++; if (o_pc !== tb_pc + 32'd8) begin n_fail++; $display("FAIL drop_next_pc: got %h want %h", o_pc, tb_pc + 32'd8); end
        tb_pc = tb_pc + 32'd8;
    endtask

    task automatic test_reset_mid_request();
        auto_rdy = 1'b0; ibus_rdy = 1'b0;
        cyc();
        n_checks++; if (o_ibus_rd !== 1'b1) begin n_fail++; $display("FAIL mid_pending_rd: got %b want 1", o_ibus_rd); end
        rst = 1'b1;
        cyc();
        n_checks++; if (o_ibus_rd !== 1'b0 || o_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got rd=%b stall=%b want 0 1", o_ibus_rd, o_fetch_stall); end
        ibus_rdy = 1'b1; ibus_data = 32'hDEAD_BEEF;
        cyc();
        rst = 1'b0; ibus_rdy = 1'b0;
        #1;
        n_checks++; if (o_ibus_rd !== 1'b1 || o_ibus_addr !== RESET_PC) begin n_fail++; $display("FAIL mid_restart: got rd=%b %h want rd=1 %h", o_ibus_rd, o_ibus_addr, RESET_PC); end
        bus_update();
        cyc();
        n_checks++; if (o_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL mid_late_rdy: got stall=%b want 1", o_fetch_stall); end
        auto_rdy = 1'b1;
        bus_update();
        cyc();
        n_checks++; if (o_pc !== RESET_PC || o_instr !== data_of(RESET_PC)) begin n_fail++; $display("FAIL mid_first: got %h/%h want %h/%h", o_pc, o_instr, RESET_PC, data_of(RESET_PC)); end
    endtask

    // Random bus latency and stalls; decode must see consecutive PCs with matching words.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] pend_addr;
        bit          pend;
        int          consumed;
        do_reset();
        auto_rdy = 1'b0;
        exp_pc = RESET_PC; pend = 1'b0; pend_addr = '0; consumed = 0;
        for (int n = 0; n < 600; n++) begin
            exec_stall = ($urandom_range(3) == 0);
            mem_stall  = ($urandom_range(3) == 0);
            if (pend) begin
                n_checks++;
                if (o_ibus_rd !== 1'b1 || o_ibus_addr !== pend_addr) begin
                    n_fail++; $display("FAIL rand_bus_hold@%0d: got rd=%b %h want rd=1 %h", n, o_ibus_rd, o_ibus_addr, pend_addr);
                end
            end
            ibus_data = data_of(o_ibus_addr);
            ibus_rdy  = o_ibus_rd && ($urandom_range(1) == 1);
            pend      = o_ibus_rd && !ibus_rdy;
            pend_addr = o_ibus_addr;
            if (o_fetch_stall) begin
                n_checks++;
                if (o_instr !== NOP) begin n_fail++; $display("FAIL rand_nop@%0d: got %h want %h", n, o_instr, NOP); end
            end else if (!exec_stall && !mem_stall) begin
                n_checks++;
                if (o_pc !== exp_pc || o_instr !== data_of(exp_pc)) begin
                    n_fail++; $display("FAIL rand_consume@%0d: got %h/%h want %h/%h", n, o_pc, o_instr, exp_pc, data_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            cyc();
        end
        n_checks++; if (consumed < 60) begin n_fail++; $display("FAIL rand_progress: got %0d want >= 60", consumed); end
        exec_stall = 1'b0; mem_stall = 1'b0; ibus_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_exec_stall();
        test_redirect_discard();
        test_jump_with_rdy();
        test_drop();
        test_reset_mid_request();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
